// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal transmit FIFO.
// Frames are sent back-to-back from the FIFO. The frame format (5-8 data
// bits, none/even/odd parity, 1 or 2 stop bits) and the bit divisor are
// sampled at the moment each byte is popped.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   tx_en          allows new frames to start (a running frame always completes)
//   clk_count_bit  clocks per bit (0 is treated as 1)
//   data_bits      0=5, 1=6, 2=7, 3=8 data bits
//   parity_mode    0/3=none, 1=even, 2=odd
//   stop2          1 = two stop bits
//   wr_en/wr_data  FIFO push request and byte
//   full/empty     FIFO status
//   level          FIFO occupancy, 0..FIFO_DEPTH
//   overflow       one-cycle pulse after a push was dropped because the FIFO was full
//   busy_flag      high whenever the transmitter is not idle
//   tx             registered serial output, idle high
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic [31:0]                   clk_count_bit,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy_flag,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;

  // Transmit FSM
  state_t            r_state;
  logic              r_tx;
  logic [31:0]       r_cnt;
  logic [2:0]        r_idx;
  logic              r_stop_sec;

  // Per-frame shadow registers, loaded on every pop
  logic [7:0]        r_byte;
  logic [2:0]        r_last;
  logic              r_par_en;
  logic              r_par;
  logic              r_stop2;
  logic [31:0]       r_div;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_stop_done;
  logic [7:0]        w_head;
  logic [7:0]        w_mask;
  logic [7:0]        w_head_m;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // Full is judged before the edge, so a same-cycle pop never makes room.
  assign w_push    = wr_en && !w_full;

  assign w_bit_end   = (r_cnt == (r_div - 32'd1));
  assign w_stop_done = (r_state == ST_STOP) && w_bit_end && (!r_stop2 || r_stop_sec);
  // A pop happens either from idle or at the last cycle of the stop period,
  // the latter giving zero-gap back-to-back frames.
  assign w_pop     = tx_en && !w_empty && ((r_state == ST_IDLE) || w_stop_done);

  assign w_head    = r_mem[r_rptr][7:0];
  assign w_mask    = 8'hFF >> (3'd3 - {1'b0, data_bits});
  assign w_head_m  = w_head & w_mask;

  // FIFO write port; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= wr_en && w_full;
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame latch: byte is stored pre-masked and parity is precomputed so the
  // FSM never looks at the live configuration inputs mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte   <= '0;
      r_last   <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_stop2  <= 1'b0;
      r_div    <= 32'd1;
    end else if (w_pop) begin
      r_byte   <= w_head_m;
      r_last   <= 3'd4 + {1'b0, data_bits};
      r_par_en <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
      r_par    <= (^w_head_m) ^ (parity_mode == 2'd2);
      r_stop2  <= stop2;
      r_div    <= (clk_count_bit == '0) ? 32'd1 : clk_count_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_sec <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_byte[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == r_last) begin
              if (r_par_en) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_sec <= 1'b0;
                r_state    <= ST_STOP;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_tx  <= r_byte[r_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_tx       <= 1'b1;
            r_stop_sec <= 1'b0;
            r_state    <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop2 && !r_stop_sec) begin
              r_stop_sec <= 1'b1;
            end else if (w_pop) begin
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign busy_flag = (r_state != ST_IDLE);
  assign tx        = r_tx;

endmodule
